pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: word address loaded into pc on reset.
REQ-002 Parameter PC_STEP, default 32'd1: sequential increment; the PC is word-addressed.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  run enable; a new fetch starts only while en=1.
REQ-006 imem_ready  in  1  instruction memory has data for the current request.
REQ-007 imem_rdata  in  32  instruction word; valid when imem_ready=1.
REQ-008 instr_done  in  1  consumer finished the current instruction with no control transfer.
REQ-009 redirect_valid  in  1  consumer requests a jump to redirect_pc.
REQ-010 redirect_pc  in  32  jump target, already word-addressed.
REQ-011 redirect_link  in  1  jump-and-link; qualifies redirect_valid.
REQ-012 pc  out  32  address of the current instruction.
REQ-013 imem_req  out  1  fetch request to instruction memory.
REQ-014 imem_addr  out  32  fetch address; equals pc while imem_req=1.
REQ-015 instr  out  32  captured instruction word.
REQ-016 instr_valid  out  1  instr is valid and awaiting completion.
REQ-017 redirect_ack  out  1  one-cycle pulse when a redirect is accepted.
REQ-018 link_we  out  1  one-cycle pulse to write the link register.
REQ-019 link_addr  out  32  return address (old pc + PC_STEP); valid when link_we=1.
REQ-020 retired  out  32  count of completed instructions.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, EXEC; all outputs are registered.
REQ-023 IDLE: go to REQ when en=1; otherwise stay in IDLE.
REQ-024 REQ: assert imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
REQ-025 WAIT: hold imem_req=1 until imem_ready=1; on that edge, capture instr<=imem_rdata, set instr_valid=1 and go to EXEC. The minimum fetch latency is 2 cycles from leaving IDLE.
REQ-026 EXEC: hold instr_valid=1 until instr_done=1 or redirect_valid=1.
REQ-027 Redirect accepted in EXEC: pc<=redirect_pc; redirect_ack=1 for one cycle; retired increments by 1.
REQ-028 If redirect_link=1 with an accepted redirect: link_we=1 and link_addr=old pc+PC_STEP in the same cycle as redirect_ack.
REQ-029 instr_done=1 in EXEC with redirect_valid=0: pc<=pc+PC_STEP; retired increments by 1.
REQ-030 redirect_valid and instr_done asserted together: the redirect wins and pc does not also step.
REQ-031 On leaving EXEC: clear instr_valid; next state is REQ if en=1, else IDLE.
REQ-032 redirect_valid, instr_done and redirect_link outside EXEC: ignored; no ack, no pc change.
REQ-033 en dropping during REQ, WAIT or EXEC: no abort; the in-flight fetch and instruction complete, then the FSM returns to IDLE.
REQ-034 pc arithmetic is modulo 2^32: 32'hFFFF_FFFF + 1 wraps to 32'h0000_0000. retired also wraps.
REQ-035 imem_ready outside WAIT: ignored.

Reset
REQ-036 When rst=1 at a clock edge, the block sets: state=IDLE, pc=RESET_PC, instr=0, and instr_valid, imem_req, redirect_ack, link_we and busy all 0.
REQ-037 The same edge also sets imem_addr=RESET_PC, link_addr=0 and retired=0.
REQ-038 rst takes priority over all other inputs in every state.
REQ-039 rst in WAIT or EXEC discards the pending instruction; imem_req is 0 on the cycle after the reset edge.

Verification
REQ-040 Sequential: en=1, imem_ready=1 the cycle after each request, instr_done on each instr_valid -> imem_addr sequence 0,1,2,3; retired=3 after the third completion.
REQ-041 Jump-and-link: pc=5 in EXEC, redirect_valid=1, redirect_pc=32'h40, redirect_link=1 -> one-cycle redirect_ack=1, link_we=1, link_addr=6; next fetch imem_addr=32'h40.
REQ-042 Collision: redirect_valid=1 and instr_done=1 in the same EXEC cycle, redirect_pc=32'h100 -> pc=32'h100 (not the old pc+1); retired increments by exactly 1.
REQ-043 Memory stall: imem_ready held low for 4 cycles -> imem_req stays 1, instr_valid stays 0; instr captures imem_rdata on the ready cycle.
REQ-044 Reset mid-fetch: rst pulsed while in WAIT with pc=7 -> next cycle pc=RESET_PC, imem_req=0, busy=0, retired=0.
REQ-045 Wrap and ignore: pc=32'hFFFF_FFFF completes with instr_done -> pc=0. redirect_valid asserted in IDLE -> no redirect_ack, pc unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction word at a time, hands it to a
// consumer, then steps or redirects the PC and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        instr_done,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_link,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        redirect_ack,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic [31:0] retired,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        redirect_ack_q;
    logic        link_we_q;
    logic [31:0] link_addr_q;
    logic [31:0] retired_q;
    logic        busy_q;

    logic [31:0] pc_step_d;
    logic [31:0] pc_target_d;
    logic        complete_d;

    // A redirect always wins over a plain completion, so the PC never steps and jumps at once.
    assign pc_step_d   = pc_q + PC_STEP;
    assign pc_target_d = redirect_valid ? redirect_pc : pc_step_d;
    assign complete_d  = redirect_valid || instr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            imem_req_q     <= 1'b0;
            imem_addr_q    <= RESET_PC;
            instr_q        <= 32'd0;
            instr_valid_q  <= 1'b0;
            redirect_ack_q <= 1'b0;
            link_we_q      <= 1'b0;
            link_addr_q    <= 32'd0;
            retired_q      <= 32'd0;
            busy_q         <= 1'b0;
        end else begin
            redirect_ack_q <= 1'b0;
            link_we_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q     <= S_REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                        busy_q      <= 1'b1;
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        state_q       <= S_EXEC;
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (complete_d) begin
                        pc_q           <= pc_target_d;
                        retired_q      <= retired_q + 32'd1;
                        instr_valid_q  <= 1'b0;
                        redirect_ack_q <= redirect_valid;
                        if (redirect_valid && redirect_link) begin
                            link_we_q   <= 1'b1;
                            link_addr_q <= pc_step_d;
                        end
                        // en is only sampled here, so dropping it mid-instruction never aborts.
                        if (en) begin
                            state_q     <= S_REQ;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= pc_target_d;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign imem_req     = imem_req_q;
    assign imem_addr    = imem_addr_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign redirect_ack = redirect_ack_q;
    assign link_we      = link_we_q;
    assign link_addr    = link_addr_q;
    assign retired      = retired_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of fetch/complete transactions plus
// hand-written sequences for en drop, ignored inputs in IDLE and reset mid-fetch.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_done;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_link;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        redirect_ack;
    logic        link_we;
    logic [31:0] link_addr;
    logic [31:0] retired;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];

    typedef struct {
        int unsigned stall;
        int unsigned hold;
        logic [31:0] rdata;
        logic        done;
        logic        rv;
        logic [31:0] rpc;
        logic        link;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic        exp_ack;
        logic        exp_lwe;
        logic [31:0] exp_laddr;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vecs[9];

    pc_sequencer #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_done    (instr_done),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_link (redirect_link),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .redirect_ack  (redirect_ack),
        .link_we       (link_we),
        .link_addr     (link_addr),
        .retired       (retired),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One fetch + execute transaction; DUT is expected to be in (or heading to) REQ.
    task automatic do_instr(input vec_t v);
        int guard;
        logic [31:0] e;
        exp_addr_q.push_back(v.exp_addr);
        guard = 0;
        while (!imem_req && guard < 20) begin
            step();
            guard++;
        end
        e = exp_addr_q.pop_front();
        if (!imem_req) begin
            n_cmp++;
            n_fail++;
            $display("FAIL fetch_timeout: imem_req never rose, expected addr %h", e);
            return;
        end
        check("fetch_addr", imem_addr, e);
        check("fetch_pc", pc, e);
        $display("fetch  addr=%h stall=%0d hold=%0d", imem_addr, v.stall, v.hold);
        step();
        check("ack_pulse_clear", {31'd0, redirect_ack}, 32'd0);
        check("link_we_pulse_clear", {31'd0, link_we}, 32'd0);
        check("wait_req", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < int'(v.stall); i++) begin
            step();
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = v.rdata;
        exp_instr_q.push_back(v.rdata);
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        check("exec_req_low", {31'd0, imem_req}, 32'd0);
        check("exec_instr", instr, exp_instr_q.pop_front());
        for (int i = 0; i < int'(v.hold); i++) begin
            step();
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_pc", pc, v.exp_addr);
            check("hold_retired", retired, v.exp_ret - 32'd1);
        end
        instr_done     = v.done;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        redirect_link  = v.link;
        step();
        instr_done     = 1'b0;
        redirect_valid = 1'b0;
        redirect_link  = 1'b0;
        redirect_pc    = 32'd0;
        check("done_ack", {31'd0, redirect_ack}, {31'd0, v.exp_ack});
        check("done_link_we", {31'd0, link_we}, {31'd0, v.exp_lwe});
        if (v.exp_lwe) check("done_link_addr", link_addr, v.exp_laddr);
        check("done_pc", pc, v.exp_pc);
        check("done_retired", retired, v.exp_ret);
        check("done_valid_clear", {31'd0, instr_valid}, 32'd0);
        $display("retire pc=%h ack=%0b link_we=%0b link_addr=%h retired=%0d",
                 pc, redirect_ack, link_we, link_addr, retired);
    endtask

    initial begin
        vec_t v;
        //            stall hold rdata          done rv rpc            link addr           pc             ack lwe laddr          ret
        vecs[0] = '{0, 0, 32'hA000_0000, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h0,   32'd1};
        vecs[1] = '{1, 1, 32'hA000_0001, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0,   32'd2};
        vecs[2] = '{0, 0, 32'hA000_0002, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 32'h0,   32'd3};
        vecs[3] = '{0, 2, 32'hA000_0003, 1'b0, 1'b1, 32'h5,         1'b0, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'h0,   32'd4};
        vecs[4] = '{4, 0, 32'hA000_0004, 1'b0, 1'b1, 32'h40,        1'b1, 32'h0000_0005, 32'h0000_0040, 1'b1, 1'b1, 32'h6,   32'd5};
        vecs[5] = '{0, 0, 32'hA000_0005, 1'b1, 1'b1, 32'h100,       1'b0, 32'h0000_0040, 32'h0000_0100, 1'b1, 1'b0, 32'h0,   32'd6};
        vecs[6] = '{2, 0, 32'hA000_0006, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h101, 32'd7};
        vecs[7] = '{0, 1, 32'hA000_0007, 1'b1, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'h0,   32'd8};
        vecs[8] = '{0, 0, 32'hA000_0008, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h0,   32'd9};

        rst = 1'b1; en = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
        instr_done = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; redirect_link = 1'b0;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_link_addr", link_addr, 32'd0);
        check("rst_ack", {31'd0, redirect_ack}, 32'd0);
        check("rst_link_we", {31'd0, link_we}, 32'd0);
        $display("reset  pc=%h busy=%0b retired=%0d", pc, busy, retired);
        rst = 1'b0;
        en  = 1'b1;
        step();
        check("start_busy", {31'd0, busy}, 32'd1);

        foreach (vecs[i]) do_instr(vecs[i]);

        // en drops while the next fetch is in flight: it completes, then IDLE.
        en = 1'b0;
        v = '{0, 0, 32'hB000_0009, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 32'd10};
        do_instr(v);
        check("endrop_busy", {31'd0, busy}, 32'd0);
        check("endrop_req", {31'd0, imem_req}, 32'd0);

        // Consumer and memory inputs in IDLE must be ignored.
        redirect_valid = 1'b1; redirect_pc = 32'h55; instr_done = 1'b1;
        redirect_link = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ack", {31'd0, redirect_ack}, 32'd0);
            check("idle_link_we", {31'd0, link_we}, 32'd0);
            check("idle_pc", pc, 32'h2);
            check("idle_retired", retired, 32'd10);
            check("idle_req", {31'd0, imem_req}, 32'd0);
        end
        $display("idle   pc=%h ack=%0b retired=%0d", pc, redirect_ack, retired);
        redirect_valid = 1'b0; redirect_pc = 32'd0; instr_done = 1'b0;
        redirect_link = 1'b0; imem_ready = 1'b0;

        // Reach pc=7 in WAIT, then reset.
        en = 1'b1;
        v = '{0, 0, 32'hC000_000A, 1'b0, 1'b1, 32'h7, 1'b0, 32'h2, 32'h7, 1'b1, 1'b0, 32'h0, 32'd11};
        do_instr(v);
        step();
        check("prerst_pc", pc, 32'h7);
        check("prerst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        imem_ready = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b0;
        en = 1'b0;
        check("midrst_pc", pc, 32'h0);
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_retired", retired, 32'd0);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_instr", instr, 32'd0);
        $display("midrst pc=%h req=%0b busy=%0b retired=%0d", pc, imem_req, busy, retired);
        step();
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
